// File: rtl/npu_pkg.sv
// Constants and types shared by the NPU operand-fetch blocks.
package npu_pkg;

    localparam int SRAM_ADDR_W  = 10;
    localparam int SRAM_DATA_W  = 8;
    localparam int MAX_TILE_DIM = 32;
    // Width of a tile dimension field; it must be able to hold MAX_TILE_DIM itself.
    localparam int DIM_W        = $clog2(MAX_TILE_DIM + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } b_rd_state_t;

endpackage

// File: rtl/sram_b_reader_if.sv
// Bundles the B-reader's command port, matrix-B SRAM port and output byte stream.
// master: the reader itself. slave: the environment (command source, SRAM, PE array).
interface sram_b_reader_if
    import npu_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) ();

    // Tile command and status
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  rows;
    logic [DIM_W-1:0]  cols;
    logic [ADDR_W-1:0] stride;
    logic              busy;
    logic              done;

    // Matrix-B SRAM port
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    // Output byte stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_eol;
    logic              out_eot;

    modport master (
        input  start, base_addr, rows, cols, stride, sram_dout, out_ready,
        output busy, done, sram_ce, sram_we, sram_addr, sram_din,
               out_valid, out_data, out_eol, out_eot
    );

    modport slave (
        output start, base_addr, rows, cols, stride, sram_dout, out_ready,
        input  busy, done, sram_ce, sram_we, sram_addr, sram_din,
               out_valid, out_data, out_eol, out_eot
    );

endinterface

// File: rtl/b_fetch_fifo.sv
// Small synchronous FIFO with first-word-fall-through output and an occupancy count.
module b_fetch_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage; cleared so the first-word output reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this array is reset on purpose (tiny, and out_data must be 0 in reset); large RAMs are not.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sram_b_reader.sv
// Streams a rows x cols tile out of the matrix-B SRAM as a valid/ready byte stream.
// Reads are throttled so buffered plus in-flight beats never exceed the FIFO depth,
// which lets the one-cycle SRAM read data be pushed unconditionally.
module sram_b_reader
    import npu_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_b_reader_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    b_rd_state_t       state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sram_ce_q, sram_ce_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              iss_eol_q, iss_eol_d;     // tags of the read issued this cycle
    logic              iss_eot_q, iss_eot_d;
    logic              inflight_q, inflight_d;   // read data arrives this cycle
    logic              tag_eol_q, tag_eol_d;     // tags travelling with that data
    logic              tag_eot_q, tag_eot_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W+1:0] fifo_rdata;
    logic              out_valid;
    logic              pop;
    logic [OCC_W-1:0]  count_nxt;
    logic              can_issue;

    // The next read position comes from the command inputs in IDLE, else from the counters.
    logic [DIM_W-1:0]  cur_rows, cur_cols, cur_row, cur_col;
    logic [ADDR_W-1:0] cur_base, cur_stride;
    logic              cur_eol, cur_eot;
    logic              issue;

    b_fetch_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .wdata ({bus.sram_dout, tag_eol_q, tag_eot_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & bus.out_ready;
    // Occupancy seen by a read issued next cycle: FIFO count then plus the read landing then.
    assign count_nxt = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign can_issue = (count_nxt + OCC_W'(sram_ce_q)) < OCC_W'(FIFO_DEPTH);

    // Select the source of the next read position and derive its row/tile end tags.
    always_comb begin
        cur_rows   = (state_q == IDLE) ? bus.rows      : rows_q;
        cur_cols   = (state_q == IDLE) ? bus.cols      : cols_q;
        cur_stride = (state_q == IDLE) ? bus.stride    : stride_q;
        cur_base   = (state_q == IDLE) ? bus.base_addr : row_base_q;
        cur_row    = (state_q == IDLE) ? '0            : row_q;
        cur_col    = (state_q == IDLE) ? '0            : col_q;
        cur_eol    = (cur_col == cur_cols - DIM_W'(1));
        cur_eot    = cur_eol && (cur_row == cur_rows - DIM_W'(1));
    end

    // FSM next state, read issue and row-major address stepping.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sram_ce_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        iss_eol_d   = iss_eol_q;
        iss_eot_d   = iss_eot_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        stride_d    = stride_q;
        row_d       = row_q;
        col_d       = col_q;
        row_base_d  = row_base_q;
        inflight_d  = sram_ce_q;
        tag_eol_d   = iss_eol_q;
        tag_eot_d   = iss_eot_q;
        issue       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.rows == '0 || bus.cols == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        rows_d   = bus.rows;
                        cols_d   = bus.cols;
                        stride_d = bus.stride;
                        issue    = 1'b1;   // FIFO is empty, so the first read is always allowed
                    end
                end
            end
            RUN: begin
                if (sram_ce_q && iss_eot_q) state_d = DRAIN;
                else if (can_issue)         issue   = 1'b1;
            end
            DRAIN: begin
                if (count_nxt == '0 && !sram_ce_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            sram_ce_d   = 1'b1;
            sram_addr_d = cur_base + ADDR_W'(cur_col);
            iss_eol_d   = cur_eol;
            iss_eot_d   = cur_eot;
            if (cur_eol) begin
                col_d      = '0;
                row_d      = cur_row + DIM_W'(1);
                row_base_d = cur_base + cur_stride;
            end else begin
                col_d      = cur_col + DIM_W'(1);
                row_d      = cur_row;
                row_base_d = cur_base;
            end
        end
    end

    // All control state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sram_ce_q   <= 1'b0;
            sram_addr_q <= '0;
            iss_eol_q   <= 1'b0;
            iss_eot_q   <= 1'b0;
            inflight_q  <= 1'b0;
            tag_eol_q   <= 1'b0;
            tag_eot_q   <= 1'b0;
            rows_q      <= '0;
            cols_q      <= '0;
            stride_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sram_ce_q   <= sram_ce_d;
            sram_addr_q <= sram_addr_d;
            iss_eol_q   <= iss_eol_d;
            iss_eot_q   <= iss_eot_d;
            inflight_q  <= inflight_d;
            tag_eol_q   <= tag_eol_d;
            tag_eot_q   <= tag_eot_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            stride_q    <= stride_d;
            row_q       <= row_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sram_ce   = sram_ce_q;
    assign bus.sram_we   = 1'b0;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_din  = '0;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = fifo_rdata[DATA_W+1:2];
    assign bus.out_eol   = fifo_rdata[1];
    assign bus.out_eot   = fifo_rdata[0];

endmodule

// File: tb/tb_sram_b_reader.sv
// Directed bench for sram_b_reader: table of tile commands plus back-pressure,
// start-while-busy and reset-mid-tile sequences. Cycle numbers are relative to T0,
// the cycle in which start is presented.
module tb_sram_b_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 3000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_b_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_b_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM contents as a function of address; registered one-cycle read.
    function automatic logic [7:0] sram_val(input logic [9:0] a);
        logic [9:0] t;
        t = a * 10'd13 + 10'd5;
        return t[7:0] ^ {6'd0, a[9:8]};
    endfunction

    always @(posedge clk) if (bus.sram_ce) bus.sram_dout <= sram_val(bus.sram_addr);

    typedef struct {
        logic [9:0] base;
        logic [5:0] rows;
        logic [5:0] cols;
        logic [9:0] stride;
        int         exp_beats;
        int         exp_done_rel;
        int         exp_first;
        int         exp_last;
        int         exp_busy;
    } vec_t;

    vec_t vecs[7];

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] iss_addr[$];
    int         iss_rel[$];
    logic [9:0] beat_bits[$];
    int         beat_rel[$];
    int done_cnt, done_rel, occ_viol, stab_viol, const_viol, valid_cnt, busy_at1;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic ready_for(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return rel[0];
            default: return (rel >= 10) ? rel[0] : 1'b0;
        endcase
    endfunction

    function automatic logic [9:0] exp_addr(input vec_t v, input int i);
        int a;
        a = int'(v.base) + (i / int'(v.cols)) * int'(v.stride) + (i % int'(v.cols));
        return a[9:0];
    endfunction

    function automatic logic [9:0] exp_beat(input vec_t v, input int i);
        logic eol, eot;
        eol = ((i % int'(v.cols)) == int'(v.cols) - 1);
        eot = eol && ((i / int'(v.cols)) == int'(v.rows) - 1);
        return {sram_val(exp_addr(v, i)), eol, eot};
    endfunction

    // Presents one tile command at T0 and logs issues, beats and done until done+3,
    // a reset at rst_rel, or the cycle limit. Entered and left just after a rising edge.
    task automatic run_tile(input vec_t v, input int mode, input int inj_rel, input int rst_rel);
        int         popped;
        bit         stall_prev;
        logic [9:0] held;
        logic [9:0] now_bits;
        int         rel;
        bit         aborted;
        iss_addr.delete(); iss_rel.delete(); beat_bits.delete(); beat_rel.delete();
        done_cnt = 0; done_rel = -1; occ_viol = 0; stab_viol = 0; const_viol = 0;
        valid_cnt = 0; busy_at1 = 0; popped = 0; stall_prev = 0; held = '0; aborted = 0;
        bus.base_addr = v.base; bus.rows = v.rows; bus.cols = v.cols; bus.stride = v.stride;
        bus.start = 1'b1;
        bus.out_ready = ready_for(mode, 0);
        rel = 0;
        while (1) begin
            @(negedge clk);
            if (rel == rst_rel) begin
                check("rst_pre_ce", int'(bus.sram_ce), 1);
                check("rst_pre_valid", int'(bus.out_valid), 1);
                rst_n = 1'b0;
                #1;
                check("rst_async_ce", int'(bus.sram_ce), 0);
                check("rst_async_valid", int'(bus.out_valid), 0);
                check("rst_async_busy", int'(bus.busy), 0);
                aborted = 1;
                break;
            end
            if (bus.sram_we !== 1'b0 || bus.sram_din !== 8'd0) const_viol++;
            if (bus.sram_ce) begin
                if (iss_addr.size() - popped >= DEPTH) occ_viol++;
                iss_addr.push_back(bus.sram_addr);
                iss_rel.push_back(rel);
            end
            now_bits = {bus.out_data, bus.out_eol, bus.out_eot};
            if (stall_prev && (!bus.out_valid || now_bits != held)) stab_viol++;
            stall_prev = bus.out_valid && !bus.out_ready;
            held = now_bits;
            if (bus.out_valid) valid_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                beat_bits.push_back(now_bits);
                beat_rel.push_back(rel);
                popped++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
            end
            if (rel == 1) busy_at1 = int'(bus.busy);
            if (done_rel >= 0 && rel >= done_rel + 3) break;
            if (rel >= LIMIT) begin
                check("done_timeout", int'(done_rel >= 0), 1);
                break;
            end
            @(posedge clk);
            #2;
            rel++;
            if (rel == inj_rel) begin
                bus.start = 1'b1; bus.base_addr = 10'd500; bus.rows = 6'd1; bus.cols = 6'd1;
                bus.stride = 10'd0;
            end else begin
                bus.start = 1'b0;
            end
            bus.out_ready = ready_for(mode, rel);
        end
        if (!aborted) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Compares the logged run against the tile's row-major model and the table values.
    task automatic check_tile(input string pfx, input vec_t v, input int mode);
        int rc, addr_err, beat_err, tim_err;
        rc = int'(v.rows) * int'(v.cols);
        addr_err = 0; beat_err = 0; tim_err = 0;
        for (int i = 0; i < iss_addr.size() && i < rc; i++)
            if (iss_addr[i] != exp_addr(v, i)) addr_err++;
        for (int i = 0; i < beat_bits.size() && i < rc; i++)
            if (beat_bits[i] != exp_beat(v, i)) beat_err++;
        check({pfx, "_issues"}, iss_addr.size(), v.exp_beats);
        check({pfx, "_beats"}, beat_bits.size(), v.exp_beats);
        check({pfx, "_addr_err"}, addr_err, 0);
        check({pfx, "_beat_err"}, beat_err, 0);
        check({pfx, "_done_cnt"}, done_cnt, 1);
        check({pfx, "_occupancy"}, occ_viol, 0);
        check({pfx, "_stable"}, stab_viol, 0);
        check({pfx, "_we_din"}, const_viol, 0);
        if (mode == 0) begin
            for (int i = 0; i < iss_rel.size(); i++) if (iss_rel[i] != i + 1) tim_err++;
            for (int i = 0; i < beat_rel.size(); i++) if (beat_rel[i] != i + 3) tim_err++;
            check({pfx, "_timing"}, tim_err, 0);
            check({pfx, "_done_rel"}, done_rel, v.exp_done_rel);
            check({pfx, "_valid_cycles"}, valid_cnt, rc);
            check({pfx, "_busy"}, busy_at1, v.exp_busy);
            if (rc > 0 && iss_addr.size() > 0) begin
                check({pfx, "_first_addr"}, int'(iss_addr[0]), v.exp_first);
                check({pfx, "_last_addr"}, int'(iss_addr[iss_addr.size()-1]), v.exp_last);
            end
        end else if (beat_rel.size() > 0) begin
            check({pfx, "_done_after_last"}, done_rel, beat_rel[beat_rel.size()-1] + 1);
        end
    endtask

    initial begin
        //          base    rows   cols   stride  beats done first last busy
        vecs[0] = '{10'd0,    6'd2,  6'd3,  10'd16, 6,    9,    0,    18,  1};
        vecs[1] = '{10'd1022, 6'd1,  6'd4,  10'd0,  4,    7,    1022, 1,   1};
        vecs[2] = '{10'd5,    6'd0,  6'd3,  10'd1,  0,    1,    0,    0,   0};
        vecs[3] = '{10'd100,  6'd3,  6'd0,  10'd1,  0,    1,    0,    0,   0};
        vecs[4] = '{10'd1000, 6'd2,  6'd2,  10'd30, 4,    7,    1000, 7,   1};
        vecs[5] = '{10'd7,    6'd1,  6'd1,  10'd0,  1,    4,    7,    7,   1};
        vecs[6] = '{10'd1023, 6'd32, 6'd32, 10'd40, 1024, 1027, 1023, 246, 1};

        bus.start = 1'b0; bus.base_addr = '0; bus.rows = '0; bus.cols = '0; bus.stride = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_sram_ce", int'(bus.sram_ce), 0);
        check("reset_sram_addr", int'(bus.sram_addr), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_eol", int'(bus.out_eol), 0);
        check("reset_out_eot", int'(bus.out_eot), 0);
        check("reset_out_data", int'(bus.out_data), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 7; i++) begin
            run_tile(vecs[i], 0, -1, -1);
            check_tile($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Back-pressure: ready toggling, then a long stall that fills the FIFO.
        run_tile(vecs[0], 1, -1, -1);
        check_tile("bp_toggle", vecs[0], 1);
        run_tile(vecs[0], 2, -1, -1);
        check_tile("bp_fill", vecs[0], 2);

        // A second start while the first tile is running must be ignored.
        run_tile(vecs[0], 0, 3, -1);
        check_tile("start_busy", vecs[0], 0);

        // Reset in the middle of a tile, then a fresh tile from its first beat.
        run_tile(vecs[0], 0, -1, 4);
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_tile(vecs[4], 0, -1, -1);
        check_tile("post_rst", vecs[4], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
